mem_resp_rv: RTL and testbench
==============================

Name: mem_resp_rv

Overview:
- Memory-side responder for the RV core's split read/write memory port: read address, write address, write data, byte strobes, read data.
- Holds a word-addressed RAM with byte-lane writes and a configurable read latency that matches the core's pMemReadWait setting.
- Decodes a small MMIO window containing a console transmit FIFO, drained by an external ready/valid consumer.
- Sits directly under the core top in simulation and FPGA builds.

Parameters:
- pAddrWidth, 12: word-address bits. RAM holds 2^pAddrWidth 32-bit words.
- pMemReadWait, 1'b1: 1 = read data registered, valid one cycle after the address; 0 = combinational read.
- pConsoleBase, 32'hFFFF_FFF0: byte address of console data register; status/clear register at pConsoleBase+4.
- pFifoLog2, 3: console FIFO depth is 2^pFifoLog2 bytes.

Ports:
- iwClk  in  1  clock; all state changes on the rising edge.
- iwRst  in  1  reset, asynchronous, active-high.
- iwReadAddr  in  32  byte read address; bits [1:0] ignored.
- iwWriteAddr  in  32  byte write address; bits [1:0] ignored.
- iwWriteData  in  32  write data, lane-aligned.
- iwWstrb  in  4  byte-lane strobes; 4'b0000 = no write this cycle.
- owReadData  out  32  read data.
- owConsoleValid  out  1  FIFO non-empty.
- iwConsoleReady  in  1  consumer accepts head byte.
- owConsoleByte  out  8  FIFO head byte; don't-care when not valid.
- owConsoleCount  out  pFifoLog2+1  bytes currently held.
- owConsoleOverflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async assert): owReadData=0, FIFO empty (count=0, valid=0), read/write pointers=0, overflow=0. RAM contents are not reset. Deassertion is synchronous to iwClk; first write is accepted on the first edge after deassertion.
- Address decode, applied to each address:
  - RAM if addr[31:pAddrWidth+2]==0.
  - CONDATA if addr[31:2]==pConsoleBase[31:2].
  - CONSTAT if addr[31:2]==(pConsoleBase+4)[31:2].
  - Anything else is unmapped.
- RAM write: at each edge with iwWstrb!=0 and write address in RAM, lane i of word addr[pAddrWidth+1:2] takes iwWriteData[8i+7:8i] for each set iwWstrb[i]. Other lanes are unchanged.
- CONDATA write with iwWstrb[0]=1 pushes iwWriteData[7:0]. Other lanes are ignored.
- CONSTAT write with any strobe clears overflow.
- Unmapped writes are dropped silently.
- Read, pMemReadWait=1: owReadData at edge n+1 is the value selected by iwReadAddr at edge n.
- Read, pMemReadWait=0: owReadData follows iwReadAddr combinationally.
- Read values:
  - RAM: word contents.
  - CONDATA: {24'b0, head byte}; reading does not pop.
  - CONSTAT: {zero-extended count in [15:8], 6'b0, overflow, full}.
  - Unmapped: 32'h0.
- Read-during-write, same RAM word, same edge: read-first. The old word is returned (registered mode); combinational mode returns the pre-edge contents. See the optional feature below.
- FIFO behaviour:
  - Circular buffer with pFifoLog2-bit pointers that wrap modulo depth; count is tracked separately.
  - full = (count==2^pFifoLog2).
  - Pop when owConsoleValid && iwConsoleReady.
  - Push when full and no pop: byte dropped, overflow set to 1, count unchanged.
  - Push and pop on the same edge: both take effect and count is unchanged. This holds even when full, so the byte is accepted and no overflow occurs.
  - Push when empty: byte visible on owConsoleByte and valid=1 the next cycle; there is no fall-through.
  - Overflow set and CONSTAT clear on the same edge: set wins.
- Reset mid-operation: FIFO contents are discarded, any in-flight read data returns to 0, and RAM writes on the reset edge are not guaranteed.

Optional Feature:
- Macro: MEM_RESP_RAW_FWD_EN
- Defined, and pMemReadWait=1: a same-edge read and write to the same RAM word return the merged word (new bytes on strobed lanes, old bytes elsewhere). This matches a write-first RAM.
- Defined, and pMemReadWait=0: the macro has no effect.
- Not defined: read-first behaviour exactly as stated above. No extra muxing logic is synthesized.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x100 with strobe 4'hF, then read 0x100 -> owReadData=32'hDEADBEEF one cycle after the read address (pMemReadWait=1). During reset, all outputs read 0.
- Write 32'h11223344 to 0x40 with strobe 4'hF, then 32'hAABBCCDD with strobe 4'b0101, then read 0x40 -> 32'h11BB33DD.
- Same-edge read and write to 0x80 (old 32'h0, new 32'h5A5A5A5A, strobe 4'hF) -> registered read returns 32'h0 without the macro and 32'h5A5A5A5A with MEM_RESP_RAW_FWD_EN.
- With iwConsoleReady=0, write bytes 0x41..0x49 to pConsoleBase (9 pushes, depth 8) -> count=8, overflow=1, CONSTAT reads 32'h0000_0803, head byte=0x41.
- Then write any value to pConsoleBase+4 -> overflow=0. Then raise iwConsoleReady -> bytes 0x41..0x48 drain one per cycle, valid drops after the last byte, count=0.
- With the FIFO full and iwConsoleReady=1, push 0x5A on the same edge as a pop -> count stays 8, overflow stays 0, 0x5A is the eighth byte out. Separately, a write to unmapped 0x8000_0000 followed by a read of the same address returns 32'h0.

Source files
------------

// File: rtl/mem_resp_rv.sv
// Memory-side responder for the RV core's split read/write memory port.
//
// Holds a word-addressed RAM with byte-lane writes and a console transmit FIFO
// mapped into a small MMIO window. A ready/valid consumer drains the FIFO.
//
// Optional macro MEM_RESP_RAW_FWD_EN: with pMemReadWait=1, a read and a write
// to the same RAM word on the same edge return the merged (new) word, as a
// write-first RAM would. Without the macro, reads are read-first.
//
// Ports:
//   iwClk, iwRst       clock; asynchronous active-high reset
//   iwReadAddr         byte read address ([1:0] ignored)
//   iwWriteAddr        byte write address ([1:0] ignored)
//   iwWriteData        lane-aligned write data
//   iwWstrb            byte-lane strobes, 0 = no write
//   owReadData         read data (registered or combinational, see pMemReadWait)
//   owConsoleValid     FIFO non-empty
//   iwConsoleReady     consumer accepts the head byte
//   owConsoleByte      FIFO head byte
//   owConsoleCount     bytes held in the FIFO
//   owConsoleOverflow  sticky flag: a push was dropped
module mem_resp_rv #(
  parameter int unsigned pAddrWidth   = 12,
  parameter bit          pMemReadWait = 1'b1,
  parameter logic [31:0] pConsoleBase = 32'hFFFF_FFF0,
  parameter int unsigned pFifoLog2    = 3
) (
  input  logic                 iwClk,
  input  logic                 iwRst,
  input  logic [31:0]          iwReadAddr,
  input  logic [31:0]          iwWriteAddr,
  input  logic [31:0]          iwWriteData,
  input  logic [3:0]           iwWstrb,
  output logic [31:0]          owReadData,
  output logic                 owConsoleValid,
  input  logic                 iwConsoleReady,
  output logic [7:0]           owConsoleByte,
  output logic [pFifoLog2:0]   owConsoleCount,
  output logic                 owConsoleOverflow
);

  localparam int unsigned Words = 2 ** pAddrWidth;
  localparam int unsigned Depth = 2 ** pFifoLog2;
  localparam logic [pFifoLog2:0] DepthC = (pFifoLog2 + 1)'(Depth);
  localparam logic [31:0] ConStat = pConsoleBase + 32'd4;

  // Address decode
  logic wr_any;
  logic wr_ram, wr_con_data, wr_con_stat;
  logic rd_ram, rd_con_data, rd_con_stat;
  logic [pAddrWidth-1:0] wr_idx, rd_idx;

  assign wr_any      = |iwWstrb;
  assign wr_ram      = wr_any && ((iwWriteAddr >> (pAddrWidth + 2)) == 32'd0);
  assign wr_con_data = wr_any && (iwWriteAddr[31:2] == pConsoleBase[31:2]);
  assign wr_con_stat = wr_any && (iwWriteAddr[31:2] == ConStat[31:2]);
  assign rd_ram      = (iwReadAddr >> (pAddrWidth + 2)) == 32'd0;
  assign rd_con_data = iwReadAddr[31:2] == pConsoleBase[31:2];
  assign rd_con_stat = iwReadAddr[31:2] == ConStat[31:2];
  assign wr_idx      = iwWriteAddr[pAddrWidth+1:2];
  assign rd_idx      = iwReadAddr[pAddrWidth+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iwReadAddr[1:0], iwWriteAddr[1:0]};

  // RAM: contents are not reset
  logic [31:0] mem [Words];

  always_ff @(posedge iwClk) begin
    if (wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (iwWstrb[i]) mem[wr_idx][8*i +: 8] <= iwWriteData[8*i +: 8];
      end
    end
  end

  // Console FIFO
  logic [7:0]           fifo_mem [Depth];
  logic [pFifoLog2-1:0] wptr_q, rptr_q;
  logic [pFifoLog2:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 full, valid, pop, push_req, push, ovf_set;

  assign full     = (count_q == DepthC);
  assign valid    = (count_q != '0);
  assign pop      = valid && iwConsoleReady;
  assign push_req = wr_con_data && iwWstrb[0];
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (ovf_set)          ovf_d = 1'b1;
    else if (wr_con_stat) ovf_d = 1'b0;
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge iwClk) begin
    if (push) fifo_mem[wptr_q] <= iwWriteData[7:0];
  end

  assign owConsoleValid    = valid;
  assign owConsoleByte     = fifo_mem[rptr_q];
  assign owConsoleCount    = count_q;
  assign owConsoleOverflow = ovf_q;

  // Read mux, evaluated on pre-edge state (read-first)
  logic [31:0] rd_val, rd_fwd;

  always_comb begin
    rd_val = '0;
    if (rd_ram)           rd_val = mem[rd_idx];
    else if (rd_con_data) rd_val = {24'b0, owConsoleByte};
    else if (rd_con_stat) rd_val = {16'b0, 8'(count_q), 6'b0, ovf_q, full};
  end

`ifdef MEM_RESP_RAW_FWD_EN
  always_comb begin
    rd_fwd = rd_val;
    if (rd_ram && wr_ram && (rd_idx == wr_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (iwWstrb[i]) rd_fwd[8*i +: 8] = iwWriteData[8*i +: 8];
      end
    end
  end
`else
  assign rd_fwd = rd_val;
`endif

  if (pMemReadWait) begin : g_rd_reg
    logic [31:0] rdata_q;
    always_ff @(posedge iwClk or posedge iwRst) begin
      if (iwRst) rdata_q <= '0;
      else       rdata_q <= rd_fwd;
    end
    assign owReadData = rdata_q;
  end else begin : g_rd_comb
    logic [31:0] unused_fwd;
    assign unused_fwd = rd_fwd;
    assign owReadData = rd_val;
  end

endmodule

// File: tb/tb_mem_resp_rv.sv
module tb_mem_resp_rv;

  localparam logic [31:0] ConBase = 32'hFFFF_FFF0;
  localparam logic [31:0] ConStat = 32'hFFFF_FFF4;

  logic        iwClk = 1'b0;
  logic        iwRst;
  logic [31:0] iwReadAddr, iwWriteAddr, iwWriteData;
  logic [3:0]  iwWstrb;
  logic [31:0] owReadData;
  logic        owConsoleValid, iwConsoleReady, owConsoleOverflow;
  logic [7:0]  owConsoleByte;
  logic [3:0]  owConsoleCount;

  int checks = 0;
  int failures = 0;

  logic [31:0] rd_q [$];   // expected registered read data
  logic [7:0]  con_q [$];  // expected console bytes in order

  mem_resp_rv dut (
    .iwClk            (iwClk),
    .iwRst            (iwRst),
    .iwReadAddr       (iwReadAddr),
    .iwWriteAddr      (iwWriteAddr),
    .iwWriteData      (iwWriteData),
    .iwWstrb          (iwWstrb),
    .owReadData       (owReadData),
    .owConsoleValid   (owConsoleValid),
    .iwConsoleReady   (iwConsoleReady),
    .owConsoleByte    (owConsoleByte),
    .owConsoleCount   (owConsoleCount),
    .owConsoleOverflow(owConsoleOverflow)
  );

  always #5 iwClk = ~iwClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change on the falling edge, so a read issued before the
  // step is visible on owReadData afterwards.
  task automatic step();
    logic [31:0] e;
    @(negedge iwClk);
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk("rdata", owReadData, e);
    end
  endtask

  task automatic idle();
    iwWstrb = 4'h0;
    iwWriteAddr = 32'h0;
    iwWriteData = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iwWriteAddr = a;
    iwWriteData = d;
    iwWstrb = s;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    iwReadAddr = a;
    rd_q.push_back(exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    iwRst = 1'b1;
    iwReadAddr = 32'h0;
    iwConsoleReady = 1'b0;
    idle();
    @(negedge iwClk);
    @(negedge iwClk);
    chk("rst_rdata", owReadData, 32'h0);
    chk("rst_valid", {31'b0, owConsoleValid}, 32'h0);
    chk("rst_count", {28'b0, owConsoleCount}, 32'h0);
    chk("rst_ovf", {31'b0, owConsoleOverflow}, 32'h0);
    iwRst = 1'b0;

    // Full-word write then read back
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    step();
    idle();
    rd(32'h100, 32'hDEAD_BEEF);
    step();

    // Byte-lane merge
    wr(32'h40, 32'h1122_3344, 4'hF);
    step();
    wr(32'h40, 32'hAABB_CCDD, 4'b0101);
    step();
    idle();
    rd(32'h40, 32'h11BB_33DD);
    step();

    // Zero 0x80, then same-edge read and write
    wr(32'h80, 32'h0, 4'hF);
    step();
    wr(32'h80, 32'h5A5A_5A5A, 4'hF);
`ifdef MEM_RESP_RAW_FWD_EN
    rd(32'h80, 32'h5A5A_5A5A);
`else
    rd(32'h80, 32'h0);
`endif
    step();
    idle();
    rd(32'h80, 32'h5A5A_5A5A);
    step();

    // Nine pushes into an 8-deep FIFO with the consumer stalled
    for (int i = 0; i < 9; i++) begin
      b = 8'h41 + 8'(i);
      wr(ConBase, {24'hABCDEF, b}, 4'h1);
      if (con_q.size() < 8) con_q.push_back(b);
      step();
    end
    idle();
    chk("full_count", {28'b0, owConsoleCount}, 32'd8);
    chk("full_ovf", {31'b0, owConsoleOverflow}, 32'd1);
    chk("full_head", {24'b0, owConsoleByte}, 32'h41);
    rd(ConStat, 32'h0000_0803);
    step();
    rd(ConBase, 32'h0000_0041);
    step();
    chk("peek_no_pop", {28'b0, owConsoleCount}, 32'd8);

    // Clear overflow
    wr(ConStat, 32'hFFFF_FFFF, 4'h2);
    step();
    idle();
    chk("ovf_clr", {31'b0, owConsoleOverflow}, 32'd0);

    // Drain
    iwConsoleReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = con_q.pop_front();
      chk("drain_valid", {31'b0, owConsoleValid}, 32'd1);
      chk("drain_byte", {24'b0, owConsoleByte}, {24'b0, b});
      step();
    end
    chk("drained_valid", {31'b0, owConsoleValid}, 32'd0);
    chk("drained_count", {28'b0, owConsoleCount}, 32'd0);

    // Refill to full, then push on the same edge as a pop
    iwConsoleReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = 8'h61 + 8'(i);
      wr(ConBase, {24'h0, b}, 4'hF);
      con_q.push_back(b);
      step();
    end
    chk("refill_count", {28'b0, owConsoleCount}, 32'd8);
    iwConsoleReady = 1'b1;
    wr(ConBase, 32'h0000_005A, 4'h1);
    b = con_q.pop_front();
    con_q.push_back(8'h5A);
    chk("pp_head", {24'b0, owConsoleByte}, {24'b0, b});
    step();
    idle();
    chk("pp_count", {28'b0, owConsoleCount}, 32'd8);
    chk("pp_ovf", {31'b0, owConsoleOverflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      b = con_q.pop_front();
      chk("pp_byte", {24'b0, owConsoleByte}, {24'b0, b});
      step();
    end
    chk("pp_empty", {31'b0, owConsoleValid}, 32'd0);
    iwConsoleReady = 1'b0;

    // Unmapped write is dropped and reads back as zero; RAM is untouched
    wr(32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
    step();
    wr(32'h8000_0100, 32'h1234_5678, 4'hF);
    step();
    idle();
    rd(32'h8000_0000, 32'h0);
    step();
    rd(32'h100, 32'hDEAD_BEEF);
    step();
    rd(ConStat, 32'h0000_0000);
    step();

    // Reset mid-operation clears in-flight read data and the FIFO
    wr(ConBase, 32'h77, 4'h1);
    iwReadAddr = 32'h100;
    step();
    idle();
    iwRst = 1'b1;
    #1;
    chk("rst2_rdata", owReadData, 32'h0);
    chk("rst2_count", {28'b0, owConsoleCount}, 32'd0);
    @(negedge iwClk);
    iwRst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
